// File: rtl/rtc_calendar_alarm.sv
// Real-time-clock core: prescaler, second..year calendar with leap-aware month
// lengths, single-field inc/dec editing with day clamping, and a minute alarm.
module rtc_calendar_alarm #(
    parameter int TICKS_PER_SEC = 32768,
    parameter int YEAR_BITS     = 7,
    parameter int RESET_YEAR    = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [2:0]           set_field,
    input  logic                 set_inc,
    input  logic                 set_dec,
    input  logic [4:0]           alarm_hour,
    input  logic [5:0]           alarm_minute,
    input  logic                 alarm_en,
    input  logic                 alarm_ack,
    output logic [5:0]           second,
    output logic [5:0]           minute,
    output logic [4:0]           hour,
    output logic [4:0]           day,
    output logic [3:0]           month,
    output logic [YEAR_BITS-1:0] year,
    output logic                 sec_pulse,
    output logic                 half_sec,
    output logic                 alarm_irq
);
    localparam int                   PW   = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]        TERM = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]        HALF = PW'(TICKS_PER_SEC / 2);
    localparam logic [YEAR_BITS-1:0] YMAX = {YEAR_BITS{1'b1}};
    localparam logic [YEAR_BITS-1:0] YRST = YEAR_BITS'(RESET_YEAR);

    logic [PW-1:0]        presc_q, presc_d;
    logic [5:0]           sec_q, sec_d, min_q, min_d;
    logic [4:0]           hour_q, hour_d, day_q, day_d;
    logic [3:0]           mon_q, mon_d;
    logic [YEAR_BITS-1:0] year_q, year_d;
    logic                 pulse_q, pulse_d, irq_q;
    logic                 edit, alarm_hit;
    logic [4:0]           dim_cur, dim_new;

    // Years are offset from 2000, so year[1:0]==0 is the leap rule through 2099.
    function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [YEAR_BITS-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim_f = 5'd30;
            4'd2:                    dim_f = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 dim_f = 5'd31;
        endcase
    endfunction

    assign dim_cur   = dim_f(mon_q, year_q);
    assign edit      = (set_field >= 3'd1) && (set_field <= 3'd6) && (set_inc ^ set_dec);
    assign alarm_hit = pulse_q && (sec_q == 6'd0) && (min_q == alarm_minute) && (hour_q == alarm_hour);

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        mon_d   = mon_q;
        year_d  = year_q;
        pulse_d = 1'b0;
        if (edit) begin
            case (set_field)
                3'd1: begin
                    presc_d = '0;
                    if (set_inc) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    else         sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                end
                3'd2: begin
                    if (set_inc) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    else         min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                end
                3'd3: begin
                    if (set_inc) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    else         hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                end
                3'd4: begin
                    if (set_inc) day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
                    else         day_d = (day_q <= 5'd1) ? dim_cur : day_q - 5'd1;
                end
                3'd5: begin
                    if (set_inc) mon_d = (mon_q >= 4'd12) ? 4'd1 : mon_q + 4'd1;
                    else         mon_d = (mon_q <= 4'd1) ? 4'd12 : mon_q - 4'd1;
                end
                3'd6: begin
                    if (set_inc) year_d = (year_q == YMAX) ? '0 : year_q + YEAR_BITS'(1);
                    else         year_d = (year_q == '0) ? YMAX : year_q - YEAR_BITS'(1);
                end
                default: ;
            endcase
        end else if (run) begin
            if (presc_q == TERM) begin
                presc_d = '0;
                pulse_d = 1'b1;
                sec_d   = sec_q + 6'd1;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    min_d = min_q + 6'd1;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        hour_d = hour_q + 5'd1;
                        if (hour_q == 5'd23) begin
                            hour_d = 5'd0;
                            day_d  = day_q + 5'd1;
                            if (day_q >= dim_cur) begin
                                day_d = 5'd1;
                                mon_d = mon_q + 4'd1;
                                if (mon_q >= 4'd12) begin
                                    mon_d  = 4'd1;
                                    year_d = year_q + YEAR_BITS'(1);
                                end
                            end
                        end
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        // Month/year changes can shorten the month under the current day.
        dim_new = dim_f(mon_d, year_d);
        if (day_d > dim_new) day_d = dim_new;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            day_q   <= 5'd1;
            mon_q   <= 4'd1;
            year_q  <= YRST;
            pulse_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            year_q  <= year_d;
            pulse_q <= pulse_d;
            if (!alarm_en)      irq_q <= 1'b0;
            else if (alarm_hit) irq_q <= 1'b1;
            else if (alarm_ack) irq_q <= 1'b0;
        end
    end

    assign second    = sec_q;
    assign minute    = min_q;
    assign hour      = hour_q;
    assign day       = day_q;
    assign month     = mon_q;
    assign year      = year_q;
    assign sec_pulse = pulse_q;
    assign half_sec  = (presc_q < HALF);
    assign alarm_irq = irq_q;
endmodule

// File: tb/tb_rtc_calendar_alarm.sv
// Bench for rtc_calendar_alarm: directed calendar/alarm scenarios plus random
// traffic, checked against a field-arithmetic calendar model.
module tb_rtc_calendar_alarm;
    localparam int TPS = 4;
    localparam int YB  = 7;
    localparam int RY  = 24;
    localparam int YMAXI = (1 << YB) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [2:0]    set_field = 3'd0;
    logic          set_inc = 1'b0;
    logic          set_dec = 1'b0;
    logic [4:0]    alarm_hour = 5'd31;
    logic [5:0]    alarm_minute = 6'd63;
    logic          alarm_en = 1'b0;
    logic          alarm_ack = 1'b0;
    logic [5:0]    second, minute;
    logic [4:0]    hour, day;
    logic [3:0]    month;
    logic [YB-1:0] year;
    logic          sec_pulse, half_sec, alarm_irq;

    int total = 0;
    int bad = 0;

    int m_presc, m_sec, m_min, m_hour, m_day, m_mon, m_year;
    bit m_pulse, m_irq;

    rtc_calendar_alarm #(.TICKS_PER_SEC(TPS), .YEAR_BITS(YB), .RESET_YEAR(RY)) dut (
        .clock(clock), .reset(reset), .run(run), .set_field(set_field),
        .set_inc(set_inc), .set_dec(set_dec), .alarm_hour(alarm_hour),
        .alarm_minute(alarm_minute), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .second(second), .minute(minute), .hour(hour), .day(day), .month(month),
        .year(year), .sec_pulse(sec_pulse), .half_sec(half_sec), .alarm_irq(alarm_irq)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mdays(input int mo, input int yr);
        int ml[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && (yr % 4) == 0) return 29;
        return ml[mo-1];
    endfunction

    function automatic int wrap(input int v, input int lo, input int hi);
        int r = hi - lo + 1;
        return (((v - lo) % r) + r) % r + lo;
    endfunction

    function automatic int mget(input int f);
        case (f)
            1: return m_sec;
            2: return m_min;
            3: return m_hour;
            4: return m_day;
            5: return m_mon;
            default: return m_year;
        endcase
    endfunction

    task automatic model_reset();
        m_presc = 0; m_sec = 0; m_min = 0; m_hour = 0;
        m_day = 1; m_mon = 1; m_year = RY; m_pulse = 0; m_irq = 0;
    endtask

    task automatic advance_second();
        m_sec++;
        if (m_sec < 60) return;
        m_sec = 0; m_min++;
        if (m_min < 60) return;
        m_min = 0; m_hour++;
        if (m_hour < 24) return;
        m_hour = 0; m_day++;
        if (m_day <= mdays(m_mon, m_year)) return;
        m_day = 1; m_mon++;
        if (m_mon <= 12) return;
        m_mon = 1; m_year = (m_year + 1) % (YMAXI + 1);
    endtask

    task automatic model_edge();
        bit ed;
        int d;
        if (!alarm_en) m_irq = 0;
        else if (m_pulse && m_sec == 0 && m_min == int'(alarm_minute) && m_hour == int'(alarm_hour)) m_irq = 1;
        else if (alarm_ack) m_irq = 0;
        ed = (set_field inside {[3'd1:3'd6]}) && (set_inc != set_dec);
        d = set_inc ? 1 : -1;
        m_pulse = 0;
        if (ed) begin
            case (int'(set_field))
                1: begin m_sec = wrap(m_sec + d, 0, 59); m_presc = 0; end
                2: m_min  = wrap(m_min + d, 0, 59);
                3: m_hour = wrap(m_hour + d, 0, 23);
                4: m_day  = wrap(m_day + d, 1, mdays(m_mon, m_year));
                5: m_mon  = wrap(m_mon + d, 1, 12);
                default: m_year = wrap(m_year + d, 0, YMAXI);
            endcase
            if (m_day > mdays(m_mon, m_year)) m_day = mdays(m_mon, m_year);
        end else if (run) begin
            m_presc++;
            if (m_presc == TPS) begin
                m_presc = 0;
                m_pulse = 1;
                advance_second();
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sec"},   int'(second),    m_sec);
        check({tag, ".min"},   int'(minute),    m_min);
        check({tag, ".hour"},  int'(hour),      m_hour);
        check({tag, ".day"},   int'(day),       m_day);
        check({tag, ".month"}, int'(month),     m_mon);
        check({tag, ".year"},  int'(year),      m_year);
        check({tag, ".pulse"}, int'(sec_pulse), int'(m_pulse));
        check({tag, ".half"},  int'(half_sec),  (m_presc < TPS / 2) ? 1 : 0);
        check({tag, ".irq"},   int'(alarm_irq), int'(m_irq));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic edit(input int f, input bit inc, input string tag);
        set_field = 3'(f); set_inc = inc; set_dec = !inc;
        step(tag);
        set_field = 3'd0; set_inc = 1'b0; set_dec = 1'b0;
    endtask

    task automatic set_to(input int f, input int target);
        bit inc = (target > mget(f));
        for (int i = 0; i < 200 && mget(f) != target; i++) edit(f, inc, "set");
    endtask

    task automatic run_to_tick(input string tag);
        run = 1'b1;
        for (int i = 0; i < 2 * TPS; i++) begin
            step(tag);
            if (m_pulse) break;
        end
        check({tag, ".tick"}, int'(sec_pulse), 1);
    endtask

    task automatic set_time(input int y, input int mo, input int d, input int h, input int mi, input int s);
        run = 1'b0;
        set_to(6, y); set_to(5, mo); set_to(4, d);
        set_to(3, h); set_to(2, mi); set_to(1, s);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".sec"},   int'(second),    0);
        check({tag, ".min"},   int'(minute),    0);
        check({tag, ".hour"},  int'(hour),      0);
        check({tag, ".day"},   int'(day),       1);
        check({tag, ".month"}, int'(month),     1);
        check({tag, ".year"},  int'(year),      RY);
        check({tag, ".pulse"}, int'(sec_pulse), 0);
        check({tag, ".half"},  int'(half_sec),  1);
        check({tag, ".irq"},   int'(alarm_irq), 0);
    endtask

    initial begin
        model_reset();
        // Reset held from time 0; release on a falling edge.
        #17;
        check_reset_vals("rst0");
        #3;
        reset = 1'b0;
        run = 1'b1;

        // Prescaler cadence and colon blink.
        for (int c = 1; c <= 12; c++) begin
            step("cad");
            check("cad.half_x", int'(half_sec), ((c % TPS) < TPS / 2) ? 1 : 0);
            if (c % TPS == 0) begin
                check("cad.pulse_x", int'(sec_pulse), 1);
                check("cad.sec_x", int'(second), c / TPS);
            end
        end

        // New-year rollover cascade.
        set_time(23, 12, 31, 23, 59, 59);
        run_to_tick("ny");
        check("ny.year_x", int'(year), 24);
        check("ny.month_x", int'(month), 1);
        check("ny.day_x", int'(day), 1);
        check("ny.hms_x", int'(hour) + int'(minute) + int'(second), 0);

        // Leap and non-leap February.
        set_time(24, 2, 28, 23, 59, 59);
        run_to_tick("leap");
        check("leap.day_x", int'(day), 29);
        check("leap.month_x", int'(month), 2);
        set_time(25, 2, 28, 23, 59, 59);
        run_to_tick("nonleap");
        check("nonleap.day_x", int'(day), 1);
        check("nonleap.month_x", int'(month), 3);

        // Day clamp, day wrap, and ignored edits.
        set_time(25, 1, 31, 10, 0, 0);
        edit(5, 1, "clamp");
        check("clamp.month_x", int'(month), 2);
        check("clamp.day_x", int'(day), 28);
        set_to(5, 1); set_to(4, 1);
        edit(4, 0, "dwrap");
        check("dwrap.day_x", int'(day), 31);
        set_field = 3'd4; set_inc = 1'b1; set_dec = 1'b1;
        step("both");
        check("both.day_x", int'(day), 31);
        set_field = 3'd7; set_dec = 1'b0;
        step("f7");
        set_field = 3'd0; set_inc = 1'b0;
        edit(6, 0, "ydec");
        set_to(6, 0);
        edit(6, 0, "ywrap");
        check("ywrap.year_x", int'(year), YMAXI);

        // Alarm set, hold, ack, and edit-does-not-trigger.
        alarm_hour = 5'd7; alarm_minute = 6'd30; alarm_en = 1'b1;
        set_time(25, 5, 10, 7, 29, 59);
        run_to_tick("alm");
        check("alm.irq_pre", int'(alarm_irq), 0);
        step("alm1");
        check("alm1.irq_x", int'(alarm_irq), 1);
        for (int i = 0; i < 100; i++) begin
            step("almhold");
            check("almhold.irq_x", int'(alarm_irq), 1);
        end
        alarm_ack = 1'b1;
        step("ack");
        alarm_ack = 1'b0;
        check("ack.irq_x", int'(alarm_irq), 0);
        set_time(25, 5, 10, 7, 29, 0);
        edit(2, 1, "almedit");
        for (int i = 0; i < 3; i++) begin
            step("almedit_hold");
            check("almedit.irq_x", int'(alarm_irq), 0);
        end

        // Asynchronous reset mid-count.
        set_time(25, 5, 10, 7, 29, 5);
        run = 1'b1;
        step("mid"); step("mid");
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        model_reset();
        #2;
        reset = 1'b0;

        // Edit on a terminal-count cycle suppresses the tick.
        step("tc"); step("tc"); step("tc");
        edit(3, 1, "tcedit");
        check("tcedit.pulse_x", int'(sec_pulse), 0);
        check("tcedit.hour_x", int'(hour), 1);
        step("tcnext");
        check("tcnext.pulse_x", int'(sec_pulse), 1);

        // Random traffic.
        alarm_hour = 5'd12; alarm_minute = 6'd35;
        set_time(27, 3, 31, 12, 34, 50);
        for (int i = 0; i < 600; i++) begin
            run = ($urandom_range(0, 9) != 0);
            alarm_en = ($urandom_range(0, 29) != 0);
            alarm_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                set_field = 3'($urandom_range(0, 7));
                set_inc = 1'($urandom_range(0, 1));
                set_dec = 1'($urandom_range(0, 1));
            end else begin
                set_field = 3'd0; set_inc = 1'b0; set_dec = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) begin
                alarm_hour = 5'(m_hour);
                alarm_minute = 6'((m_min + 1) % 60);
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
